regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port register file with an integrated per-register scoreboard and optional write-to-read bypass. It is the next-generation general-purpose register file for the pipelined core:
- Decode reads any number of operands combinationally, together with a per-operand ready flag.
- Issue reserves destination registers.
- Writeback retires reservations while writing data.
- Flush discards all outstanding reservations on a pipeline redirect.

## Interface
Parameters
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports (>=1)
- CNT_W, 2, pending-counter width per register; max outstanding writes per register = 2^CNT_W-1
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending
- BYPASS, 1, 1 = same-cycle writeback data and ready forwarded to read ports

Ports
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk
- raddr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rready  out  NUM_RD  1 = register at raddr[i] has no outstanding write
- we  in  1  writeback valid
- waddr  in  ADDR_W  writeback address
- wdata  in  DATA_W  writeback data
- issue_valid  in  1  reserve issue_addr as destination of an in-flight instruction
- issue_addr  in  ADDR_W  register being reserved
- issue_ready  out  1  1 = reservation accepted this cycle if issue_valid
- flush  in  1  clear all pending counters
- pending_any  out  1  1 = at least one counter nonzero
- wb_err  out  1  sticky: writeback retired a register whose counter was 0

## Operation
- State:
  - data array of 2^ADDR_W × DATA_W
  - counter array of 2^ADDR_W × CNT_W
  - wb_err flag
- Reset: all data words 0, all counters 0, wb_err 0. Reset has priority over every other input.
- Write: if we and not (ZERO_REG and waddr==0), data[waddr] <= wdata at the clock edge. Writes to register 0 with ZERO_REG=1 are dropped.
- Counter update, per register r, at each edge, in priority order:
  1. flush: count <= 0 for all r. Issue is dropped. A data write in the same cycle still occurs.
  2. inc = issue_valid & issue_ready & issue_addr==r. dec = we & waddr==r & count!=0.
     - inc and not dec: count+1.
     - dec and not inc: count-1.
     - both or neither: count unchanged.
- Underflow: we to a register whose counter is 0, with no flush, sets wb_err <= 1. The counter stays 0 and the data write still happens. wb_err clears only on reset.
- issue_ready = not (count[issue_addr] == 2^CNT_W-1), combinational. A same-cycle decrement on the same register does not raise issue_ready.
- ZERO_REG=1, register 0:
  - reads return 0
  - rready = 1
  - issue_ready = 1 for issue_addr 0
  - issue to 0 never increments its counter
  - we to 0 never sets wb_err
- Read port i, combinational:
  - BYPASS=1 and we and waddr==raddr[i] and raddr[i] valid for writes: rdata = wdata. Otherwise rdata = data[raddr[i]].
  - rready[i] = (count==0), or, with BYPASS=1, (count==1 and we and waddr==raddr[i]).
- pending_any = OR of all counters != 0, from registered state only.

## Timing
- Read latency 0: rdata, rready, issue_ready and pending_any are combinational from inputs and state.
- Write-to-read:
  - BYPASS=0: new data visible 1 cycle after the we edge.
  - BYPASS=1: visible in the same cycle.
- Issue-to-rready: rready falls in the cycle after the accepted issue.
- Flush: effect is visible in the cycle after the flush edge.
- Reset values of outputs after the reset edge:
  - rdata all 0
  - rready all 1
  - issue_ready 1
  - pending_any 0
  - wb_err 0
- Reset asserted mid-operation clears outstanding counters and wb_err on that edge regardless of we, issue_valid or flush.
- No internal combinational path from rdata or rready to issue_ready. Outputs depend only on inputs and state, so there are no loops.

## Test plan
- Reset then read: after reset, write r5=0xDEADBEEF, then read r5 on port 0 and r0 on port 1. Required: 0xDEADBEEF and 0x0, both rready=1. Write 0x1234 to r0; r0 still reads 0.
- Bypass:
  - BYPASS=1: we r7=0xA5A5A5A5 with raddr0=7 gives rdata0=0xA5A5A5A5 in the same cycle.
  - BYPASS=0: the same stimulus returns the old value, and the new value appears one cycle later.
- Scoreboard saturation, CNT_W=2: issue r3 three times.
  - Required: rready for r3 = 0, issue_ready=0 for r3, pending_any=1.
  - Then three writebacks to r3: rready returns 1 on the third, pending_any=0.
- Simultaneous issue and writeback on r9 with count=1: count stays 1 and rready stays 0. Then one more writeback leaves count 0.
- Flush: with r2 and r4 pending, assert flush together with issue r6 and we r2=0x55. Required next cycle:
  - all counters 0, pending_any=0
  - r2 reads 0x55
  - r6 is not pending
  - wb_err unchanged
- Underflow and reset mid-operation: we to r8 with count 0 sets wb_err=1 and writes the data. Then assert reset while issue_valid=1. Required next cycle: wb_err=0, all counters 0, all data 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with per-register pending-write scoreboard and optional write bypass
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int CNT_W    = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rready,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic                     issue_ready,
   input  logic                     flush,
   output logic                     pending_any,
   output logic                     wb_err
);
   localparam int               DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam bit               ZR      = ZERO_REG != 0;
   localparam bit               BP      = BYPASS != 0;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [CNT_W-1:0]  cnt_q  [DEPTH];
   logic [CNT_W-1:0]  cnt_d  [DEPTH];
   logic [DEPTH-1:0]  inc, dec;
   logic              wb_err_q, wb_err_d;
   logic              wr_ok, issue_ok;
   assign wr_ok       = we & ~(ZR & (waddr == '0));
   assign issue_ready = (ZR & (issue_addr == '0)) | (cnt_q[issue_addr] != CNT_MAX);
   assign issue_ok    = issue_valid & issue_ready & ~(ZR & (issue_addr == '0));
   assign wb_err_d    = wb_err_q | (wr_ok & ~flush & (cnt_q[waddr] == '0));
   assign wb_err      = wb_err_q;
   // A simultaneous issue and retire on one register cancel out; flush overrides both
   always_comb begin
      inc         = '0;
      dec         = '0;
      pending_any = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
         inc[r]      = issue_ok & (issue_addr == ADDR_W'(r));
         dec[r]      = we & (waddr == ADDR_W'(r)) & (cnt_q[r] != '0);
         cnt_d[r]    = flush ? '0 :
                       (inc[r] & ~dec[r]) ? cnt_q[r] + 1'b1 :
                       (dec[r] & ~inc[r]) ? cnt_q[r] - 1'b1 : cnt_q[r];
         pending_any = pending_any | (cnt_q[r] != '0);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            data_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         wb_err_q <= 1'b0;
      end else begin
         if (wr_ok) data_q[waddr] <= wdata;
         for (int r = 0; r < DEPTH; r++) cnt_q[r] <= cnt_d[r];
         wb_err_q <= wb_err_d;
      end
   end
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              zr, hit;
      assign a         = raddr[i*ADDR_W +: ADDR_W];
      assign zr        = ZR & (a == '0);
      assign hit       = BP & we & (waddr == a);
      assign rdata[i*DATA_W +: DATA_W] = zr ? '0 : hit ? wdata : data_q[a];
      assign rready[i] = zr | (cnt_q[a] == '0) | (hit & (cnt_q[a] == CNT_W'(1)));
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus randomized run against a behavioural model, BYPASS=1 and BYPASS=0 side by side
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        reset, we, issue_valid, flush;
   logic [4:0]  waddr, issue_addr;
   logic [31:0] wdata;
   logic [9:0]  raddr;
   logic [63:0] rdata_b, rdata_n;
   logic [1:0]  rready_b, rready_n;
   logic        ir_b, ir_n, pa_b, pa_n, err_b, err_n;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   regfile_sb #(.BYPASS(1)) dut_b (
      .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rready(rready_b),
      .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid), .issue_addr(issue_addr),
      .issue_ready(ir_b), .flush(flush), .pending_any(pa_b), .wb_err(err_b)
   );
   regfile_sb #(.BYPASS(0)) dut_n (
      .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_n), .rready(rready_n),
      .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid), .issue_addr(issue_addr),
      .issue_ready(ir_n), .flush(flush), .pending_any(pa_n), .wb_err(err_n)
   );

   logic [31:0] mem [32];
   int          cnt [32];
   bit          err;

   function automatic logic [31:0] m_rd(input logic [4:0] a, input bit bp);
      if (a == 0) return 0;
      if (bp && we && waddr == a) return wdata;
      return mem[a];
   endfunction
   function automatic bit m_rr(input logic [4:0] a, input bit bp);
      return a == 0 || cnt[a] == 0 || (bp && we && waddr == a && cnt[a] == 1);
   endfunction
   function automatic bit m_ir();
      return issue_addr == 0 || cnt[issue_addr] < 3;
   endfunction
   function automatic bit m_pa();
      for (int r = 0; r < 32; r++) if (cnt[r] != 0) return 1;
      return 0;
   endfunction

   task automatic m_step();
      bit inc, dec;
      if (reset) begin
         for (int r = 0; r < 32; r++) begin
            mem[r] = 0;
            cnt[r] = 0;
         end
         err = 0;
      end else begin
         inc = issue_valid && m_ir() && issue_addr != 0;
         dec = we && cnt[waddr] > 0;
         if (we && waddr != 0) begin
            if (cnt[waddr] == 0 && !flush) err = 1;
            mem[waddr] = wdata;
         end
         if (flush) for (int r = 0; r < 32; r++) cnt[r] = 0;
         else begin
            if (inc) cnt[issue_addr]++;
            if (dec) cnt[waddr]--;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_check(input string tag);
      logic [4:0] a;
      for (int p = 0; p < 2; p++) begin
         a = raddr[p*5 +: 5];
         chk($sformatf("%s byp rdata%0d", tag, p), rdata_b[p*32 +: 32], m_rd(a, 1));
         chk($sformatf("%s nobyp rdata%0d", tag, p), rdata_n[p*32 +: 32], m_rd(a, 0));
         chk($sformatf("%s byp rready%0d", tag, p), 32'(rready_b[p]), 32'(m_rr(a, 1)));
         chk($sformatf("%s nobyp rready%0d", tag, p), 32'(rready_n[p]), 32'(m_rr(a, 0)));
      end
      chk({tag, " byp issue_ready"}, 32'(ir_b), 32'(m_ir()));
      chk({tag, " nobyp issue_ready"}, 32'(ir_n), 32'(m_ir()));
      chk({tag, " byp pending_any"}, 32'(pa_b), 32'(m_pa()));
      chk({tag, " nobyp pending_any"}, 32'(pa_n), 32'(m_pa()));
      chk({tag, " byp wb_err"}, 32'(err_b), 32'(err));
      chk({tag, " nobyp wb_err"}, 32'(err_n), 32'(err));
   endtask

   task automatic drive(input bit rst, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                        input bit iv, input logic [4:0] ia, input bit fl,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      reset = rst; we = w; waddr = wa; wdata = wd;
      issue_valid = iv; issue_addr = ia; flush = fl; raddr = {ra1, ra0};
   endtask

   task automatic clock_step();
      @(posedge clk);
      m_step();
      @(negedge clk);
   endtask

   typedef struct {
      bit rst; bit we; logic [4:0] wa; logic [31:0] wd; bit iv; logic [4:0] ia; bit fl;
      logic [4:0] ra0; logic [4:0] ra1;
      logic [31:0] rd0; bit rr0; logic [31:0] rd1; bit rr1; bit ir; bit pa; bit err; logic [31:0] rd0n;
   } vec_t;
   vec_t tv[$];

   task automatic add(input bit rst, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                      input bit iv, input logic [4:0] ia, input bit fl,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [31:0] rd0, input bit rr0, input logic [31:0] rd1, input bit rr1,
                      input bit ir, input bit pa, input bit e, input logic [31:0] rd0n);
      tv.push_back('{rst, w, wa, wd, iv, ia, fl, ra0, ra1, rd0, rr0, rd1, rr1, ir, pa, e, rd0n});
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      clock_step();
      // reset then read, zero register
      add(0, 0, 0, 0,            1, 5, 0, 5, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      add(0, 1, 5, 'hDEADBEEF,   0, 0, 0, 5, 0, 'hDEADBEEF, 1, 0, 1, 1, 1, 0, 0);
      add(0, 1, 0, 'h1234,       0, 0, 0, 5, 0, 'hDEADBEEF, 1, 0, 1, 1, 0, 0, 'hDEADBEEF);
      add(0, 0, 0, 0,            0, 0, 0, 5, 0, 'hDEADBEEF, 1, 0, 1, 1, 0, 0, 'hDEADBEEF);
      // bypass
      add(0, 0, 0, 0,            1, 7, 0, 7, 5, 0, 1, 'hDEADBEEF, 1, 1, 0, 0, 0);
      add(0, 1, 7, 'hA5A5A5A5,   0, 0, 0, 7, 7, 'hA5A5A5A5, 1, 'hA5A5A5A5, 1, 1, 1, 0, 0);
      add(0, 0, 0, 0,            0, 0, 0, 7, 7, 'hA5A5A5A5, 1, 'hA5A5A5A5, 1, 1, 0, 0, 'hA5A5A5A5);
      // saturation on r3
      add(0, 0, 0, 0,            1, 3, 0, 3, 3, 0, 1, 0, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0,            1, 3, 0, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0,            1, 3, 0, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0,            1, 3, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 1, 3, 'h11,         0, 3, 0, 3, 3, 'h11, 0, 'h11, 0, 0, 1, 0, 0);
      add(0, 1, 3, 'h22,         0, 3, 0, 3, 3, 'h22, 0, 'h22, 0, 1, 1, 0, 'h11);
      add(0, 1, 3, 'h33,         0, 3, 0, 3, 3, 'h33, 1, 'h33, 1, 1, 1, 0, 'h22);
      add(0, 0, 0, 0,            0, 3, 0, 3, 3, 'h33, 1, 'h33, 1, 1, 0, 0, 'h33);
      // simultaneous issue and writeback on r9
      add(0, 0, 0, 0,            1, 9, 0, 9, 9, 0, 1, 0, 1, 1, 0, 0, 0);
      add(0, 1, 9, 'h99,         1, 9, 0, 9, 9, 'h99, 1, 'h99, 1, 1, 1, 0, 0);
      add(0, 0, 0, 0,            0, 9, 0, 9, 9, 'h99, 0, 'h99, 0, 1, 1, 0, 'h99);
      add(0, 1, 9, 'h9A,         0, 9, 0, 9, 9, 'h9A, 1, 'h9A, 1, 1, 1, 0, 'h99);
      add(0, 0, 0, 0,            0, 9, 0, 9, 9, 'h9A, 1, 'h9A, 1, 1, 0, 0, 'h9A);
      // flush with r2, r4 pending
      add(0, 0, 0, 0,            1, 2, 0, 2, 4, 0, 1, 0, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0,            1, 4, 0, 2, 4, 0, 0, 0, 1, 1, 1, 0, 0);
      add(0, 1, 2, 'h55,         1, 6, 1, 2, 4, 'h55, 1, 0, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0,            0, 6, 0, 2, 6, 'h55, 1, 0, 1, 1, 0, 0, 'h55);
      // underflow, then reset mid-operation
      add(0, 1, 8, 'h88,         0, 0, 0, 8, 8, 'h88, 1, 'h88, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0,            1, 8, 0, 8, 5, 'h88, 1, 'hDEADBEEF, 1, 1, 0, 1, 'h88);
      add(1, 1, 5, 'hFFFF,       1, 10, 0, 8, 5, 'h88, 0, 'hFFFF, 1, 1, 1, 1, 'h88);
      add(0, 0, 0, 0,            0, 0, 0, 8, 5, 0, 1, 0, 1, 1, 0, 0, 0);
      foreach (tv[k]) begin
         drive(tv[k].rst, tv[k].we, tv[k].wa, tv[k].wd, tv[k].iv, tv[k].ia, tv[k].fl, tv[k].ra0, tv[k].ra1);
         #1;
         chk($sformatf("v%0d rdata0", k), rdata_b[31:0], tv[k].rd0);
         chk($sformatf("v%0d rready0", k), 32'(rready_b[0]), 32'(tv[k].rr0));
         chk($sformatf("v%0d rdata1", k), rdata_b[63:32], tv[k].rd1);
         chk($sformatf("v%0d rready1", k), 32'(rready_b[1]), 32'(tv[k].rr1));
         chk($sformatf("v%0d issue_ready", k), 32'(ir_b), 32'(tv[k].ir));
         chk($sformatf("v%0d pending_any", k), 32'(pa_b), 32'(tv[k].pa));
         chk($sformatf("v%0d wb_err", k), 32'(err_b), 32'(tv[k].err));
         chk($sformatf("v%0d nobyp rdata0", k), rdata_n[31:0], tv[k].rd0n);
         model_check($sformatf("v%0d", k));
         clock_step();
      end
      for (int n = 0; n < 800; n++) begin
         drive($urandom_range(0, 59) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 24) == 0,
               5'($urandom_range(0, 8)), 5'($urandom));
         #1;
         model_check($sformatf("r%0d", n));
         clock_step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
